axi_slave_pop_fsm_wr: RTL and testbench

Write-request pop stage of the AXI slave request path. Consumes completed write requests from the AW FIFO (one entry per burst, written on the WLAST beat) and their data beats from the W FIFO. For each request it registers the tag in the request recorder, presents one memory-write header descriptor to the TLP builder, then streams exactly AWLEN+1 data beats with a last marker. Handshakes on both output channels are valid/ready.

---
 rtl/axi_slave_pop_fsm_wr.sv | 153 +++++++++++++++
 tb/tb_axi_slave_pop_fsm_wr.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_pop_fsm_wr.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axi_slave_pop_fsm_wr
//
// Write-request pop stage of the AXI slave request path. Takes one completed
// write burst from the AW FIFO, records its tag, offers one memory-write
// header descriptor to the TLP builder, then streams AWLEN+1 data beats from
// the W FIFO with a last marker. One burst is handled at a time.
//
// Ports
//   axi_clk, ARESET          clock, synchronous active-high reset
//   aw_fifo_*                AW FIFO read side (first-word-fall-through)
//   w_fifo_*                 W FIFO read side (first-word-fall-through)
//   rec_wr_en/addr/data      request recorder write port
//   hdr_valid/hdr_ready      header handshake; hdr_* descriptor fields
//   data_valid/data_ready    data handshake; data, data_last
// -----------------------------------------------------------------------------
module axi_slave_pop_fsm_wr #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 5,
  parameter int TAG_WIDTH    = 8,
  parameter int DATA_WIDTH   = 256,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int AWFIFO_ENTRY = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 3 + STRB_WIDTH
) (
  input  logic                    axi_clk,
  input  logic                    ARESET,
  // AW FIFO
  input  logic                    aw_fifo_empty,
  input  logic [AWFIFO_ENTRY-1:0] aw_fifo_rd_data,
  output logic                    aw_fifo_rd_en,
  // W FIFO
  input  logic                    w_fifo_empty,
  input  logic [DATA_WIDTH-1:0]   w_fifo_rd_data,
  output logic                    w_fifo_rd_en,
  // request recorder
  output logic                    rec_wr_en,
  output logic [TAG_WIDTH-1:0]    rec_wr_addr,
  output logic [ID_WIDTH:0]       rec_wr_data,
  // header descriptor
  output logic                    hdr_valid,
  input  logic                    hdr_ready,
  output logic [ADDR_WIDTH-1:0]   hdr_addr,
  output logic                    hdr_fmt_4dw,
  output logic [9:0]              hdr_length,
  output logic [TAG_WIDTH-1:0]    hdr_tag,
  output logic [3:0]              hdr_first_be,
  output logic [3:0]              hdr_last_be,
  output logic [2:0]              hdr_user,
  // data beats
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    data_last
);

  typedef enum logic [1:0] {
    POP_IDLE,
    POP_HDR,
    POP_DATA
  } state_t;

  // AW FIFO entry layout, MSB first.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [2:0]            user;
    logic [STRB_WIDTH-1:0] wstrb_last;
  } aw_entry_t;

  aw_entry_t head;
  aw_entry_t req_q;
  state_t    state;
  logic [7:0] beat_cnt;

  logic        in_hdr;
  logic        in_data;
  logic        pop_aw;
  logic        data_fire;
  logic [15:0] req_bytes;

  assign head = aw_entry_t'(aw_fifo_rd_data);

  // Strobes are masked while ARESET is high so nothing is popped from a FIFO
  // during the cycle in which everything is being reset.
  assign in_hdr    = (state == POP_HDR);
  assign in_data   = (state == POP_DATA) && !ARESET;
  assign pop_aw    = (state == POP_IDLE) && !aw_fifo_empty && !ARESET;
  assign data_fire = data_valid && data_ready;

  // NOTE: every output is a continuous assignment with a defined value in all
  // states (gated to 0 when inactive), so no storage can be inferred by accident.
  assign aw_fifo_rd_en = pop_aw;
  assign rec_wr_en     = pop_aw;
  assign rec_wr_addr   = pop_aw ? TAG_WIDTH'(head.id) : '0;
  assign rec_wr_data   = pop_aw ? {1'b1, head.id} : '0;

  // Burst size in bytes; a 4096-byte burst wraps bits [11:2] to 0, which is
  // the PCIe encoding for 1024 DW.
  assign req_bytes = (16'(req_q.len) + 16'd1) << req_q.size;

  assign hdr_valid    = in_hdr;
  assign hdr_addr     = in_hdr ? {req_q.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign hdr_fmt_4dw  = in_hdr && (req_q.addr[ADDR_WIDTH-1:32] != '0);
  assign hdr_length   = in_hdr ? req_bytes[11:2] : '0;
  assign hdr_tag      = in_hdr ? TAG_WIDTH'(req_q.id) : '0;
  assign hdr_first_be = in_hdr ? 4'hF : 4'h0;
  // A single-DW payload carries all its enables in first_be.
  assign hdr_last_be  = (!in_hdr || req_bytes[11:2] == 10'd1) ? 4'h0 : req_q.wstrb_last[3:0];
  assign hdr_user     = in_hdr ? req_q.user : '0;

  assign data_valid   = in_data && !w_fifo_empty;
  assign data         = in_data ? w_fifo_rd_data : '0;
  assign data_last    = in_data && (beat_cnt == 8'd0);
  assign w_fifo_rd_en = data_fire;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge axi_clk) begin
    if (ARESET) begin
      state    <= POP_IDLE;
      req_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        POP_IDLE: begin
          if (!aw_fifo_empty) begin
            req_q <= head;
            state <= POP_HDR;
          end
        end
        POP_HDR: begin
          if (hdr_ready) begin
            beat_cnt <= req_q.len;
            state    <= POP_DATA;
          end
        end
        POP_DATA: begin
          // An empty W FIFO only stalls data_valid; the burst is still owed.
          if (data_fire) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd0) state <= POP_IDLE;
          end
        end
        default: state <= POP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_pop_fsm_wr.sv
`timescale 1ns/1ps
module tb_axi_slave_pop_fsm_wr;

  localparam int AW  = 64;
  localparam int IDW = 5;
  localparam int TW  = 8;
  localparam int DW  = 256;
  localparam int SW  = DW / 8;
  localparam int ENT = IDW + AW + 8 + 3 + 2 + 3 + SW;

  logic           axi_clk;
  logic           ARESET;
  logic           aw_fifo_empty;
  logic [ENT-1:0] aw_fifo_rd_data;
  logic           aw_fifo_rd_en;
  logic           w_fifo_empty;
  logic [DW-1:0]  w_fifo_rd_data;
  logic           w_fifo_rd_en;
  logic           rec_wr_en;
  logic [TW-1:0]  rec_wr_addr;
  logic [IDW:0]   rec_wr_data;
  logic           hdr_valid;
  logic           hdr_ready;
  logic [AW-1:0]  hdr_addr;
  logic           hdr_fmt_4dw;
  logic [9:0]     hdr_length;
  logic [TW-1:0]  hdr_tag;
  logic [3:0]     hdr_first_be;
  logic [3:0]     hdr_last_be;
  logic [2:0]     hdr_user;
  logic           data_valid;
  logic           data_ready;
  logic [DW-1:0]  data;
  logic           data_last;

  axi_slave_pop_fsm_wr dut (
    .axi_clk        (axi_clk),
    .ARESET         (ARESET),
    .aw_fifo_empty  (aw_fifo_empty),
    .aw_fifo_rd_data(aw_fifo_rd_data),
    .aw_fifo_rd_en  (aw_fifo_rd_en),
    .w_fifo_empty   (w_fifo_empty),
    .w_fifo_rd_data (w_fifo_rd_data),
    .w_fifo_rd_en   (w_fifo_rd_en),
    .rec_wr_en      (rec_wr_en),
    .rec_wr_addr    (rec_wr_addr),
    .rec_wr_data    (rec_wr_data),
    .hdr_valid      (hdr_valid),
    .hdr_ready      (hdr_ready),
    .hdr_addr       (hdr_addr),
    .hdr_fmt_4dw    (hdr_fmt_4dw),
    .hdr_length     (hdr_length),
    .hdr_tag        (hdr_tag),
    .hdr_first_be   (hdr_first_be),
    .hdr_last_be    (hdr_last_be),
    .hdr_user       (hdr_user),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .data           (data),
    .data_last      (data_last)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          fmt;
    logic [9:0]    len;
    logic [TW-1:0] tag;
    logic [3:0]    fbe;
    logic [3:0]    lbe;
    logic [2:0]    user;
  } hdr_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  // FIFO models and scoreboards
  logic [ENT-1:0]   aw_q[$];
  logic [DW-1:0]    w_q[$];
  hdr_t             exp_hdr[$];
  beat_t            exp_beat[$];
  logic [TW+IDW:0]  exp_rec[$];
  int               aw_rd_cyc[$];
  int               last_hs_cyc[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   w_pops = 0;
  int   hs_cnt = 0;
  logic w_gap = 1'b0;

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input logic [4:0] id, input int i);
    logic [31:0] w;
    w = {3'b000, id, 8'hB0, 16'(i)};
    return {8{w}};
  endfunction

  // FIFO model: pops on the edge, refreshes outputs 3 ns later, after the
  // stimulus process (which acts at +2 ns) has pushed or flushed.
  initial begin
    aw_fifo_empty   = 1'b1;
    aw_fifo_rd_data = '0;
    w_fifo_empty    = 1'b1;
    w_fifo_rd_data  = '0;
    forever begin
      @(posedge axi_clk);
      if (aw_fifo_rd_en && aw_q.size() > 0) void'(aw_q.pop_front());
      if (w_fifo_rd_en && w_q.size() > 0) void'(w_q.pop_front());
      #3;
      aw_fifo_empty   = (aw_q.size() == 0);
      aw_fifo_rd_data = (aw_q.size() > 0) ? aw_q[0] : '0;
      w_fifo_empty    = (w_q.size() == 0) || w_gap;
      w_fifo_rd_data  = (w_q.size() > 0) ? w_q[0] : '0;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboards.
  initial begin
    forever begin
      @(negedge axi_clk);
      if (rec_wr_en || aw_fifo_rd_en) begin
        check("rec_en_with_pop", rec_wr_en, aw_fifo_rd_en);
        check("rec_expected", exp_rec.size() != 0, 1);
        if (exp_rec.size() != 0) check("rec_addr_data", {rec_wr_addr, rec_wr_data}, exp_rec.pop_front());
      end
      if (aw_fifo_rd_en) aw_rd_cyc.push_back(cyc);
      if (hdr_valid) begin
        check("hdr_expected", exp_hdr.size() != 0, 1);
        if (exp_hdr.size() != 0) begin
          check("hdr_fields", {hdr_addr, hdr_fmt_4dw, hdr_length, hdr_tag, hdr_first_be, hdr_last_be, hdr_user}, exp_hdr[0]);
          if (hdr_ready) void'(exp_hdr.pop_front());
        end
      end
      if (data_valid) begin
        check("beat_expected", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0) begin
          check("beat_data_last", {data, data_last}, exp_beat[0]);
          if (data_ready) void'(exp_beat.pop_front());
        end
        if (data_ready) begin
          hs_cnt++;
          if (data_last) last_hs_cyc.push_back(cyc);
        end
      end
      if (hdr_valid && data_valid) check("hdr_data_exclusive", 1, 0);
      if (w_fifo_rd_en || data_valid) check("w_rd_en", w_fifo_rd_en, data_valid && data_ready);
      if (w_fifo_rd_en) w_pops++;
    end
  end

  // Queue one request: AW entry, its W beats, and the hand-computed header.
  task automatic issue(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [2:0] user, input logic [31:0] strb,
                       input logic [9:0] e_len, input logic [3:0] e_lbe, input logic e_fmt);
    aw_q.push_back({id, addr, len, size, 2'b01, user, strb});
    for (int i = 0; i <= int'(len); i++) begin
      w_q.push_back(beat(id, i));
      exp_beat.push_back('{d: beat(id, i), last: (i == int'(len))});
    end
    exp_rec.push_back({8'(id), 1'b1, id});
    exp_hdr.push_back('{addr: {addr[63:2], 2'b00}, fmt: e_fmt, len: e_len, tag: 8'(id),
                        fbe: 4'hF, lbe: e_lbe, user: user});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_beat.size() != 0 || exp_hdr.size() != 0 || exp_rec.size() != 0) && n < budget) begin
      @(posedge axi_clk); #2;
      n++;
    end
    check({name, "_drained"}, (exp_beat.size() == 0 && exp_hdr.size() == 0 && exp_rec.size() == 0), 1);
  endtask

  task automatic check_idle(input string name);
    @(negedge axi_clk);
    check(name, {hdr_valid, data_valid, aw_fifo_rd_en, w_fifo_rd_en, rec_wr_en}, 0);
    @(posedge axi_clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    ARESET     = 1'b1;
    hdr_ready  = 1'b1;
    data_ready = 1'b1;

    // Reset state: every output low.
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    check("reset_outputs", {aw_fifo_rd_en, w_fifo_rd_en, rec_wr_en, rec_wr_addr, rec_wr_data,
                            hdr_valid, hdr_addr, hdr_fmt_4dw, hdr_length, hdr_tag, hdr_first_be,
                            hdr_last_be, hdr_user, data_valid, data, data_last}, 0);
    @(posedge axi_clk); #2;
    ARESET = 1'b0;
    @(posedge axi_clk); #2;

    // T1: 4 beats x 32 bytes = 128 bytes = 32 DW; header cycle 1, data cycle 2.
    base = w_pops;
    issue(5'd3, 64'h1000, 8'd3, 3'd5, 3'b001, 32'hFFFF_FFFF, 10'd32, 4'hF, 1'b0);
    @(negedge axi_clk);
    check("t1_cycle0_aw_rd_en", aw_fifo_rd_en, 1);
    check("t1_cycle0_rec_wr_en", rec_wr_en, 1);
    @(negedge axi_clk);
    check("t1_cycle1_hdr_valid", hdr_valid, 1);
    @(negedge axi_clk);
    check("t1_cycle2_data_valid", data_valid, 1);
    @(posedge axi_clk); #2;
    wait_drain("t1", 50);
    check("t1_w_pops", w_pops - base, 4);
    check_idle("t1_idle");

    // T2: 4-DW address above 4 GB, single DW payload -> last_be 0.
    issue(5'd7, 64'h1_0000_0000, 8'd0, 3'd2, 3'b010, 32'h0000_000F, 10'd1, 4'h0, 1'b1);
    wait_drain("t2", 50);
    check_idle("t2_idle");

    // T3: unaligned address low bits dropped; 2 DW -> last_be from strobes.
    issue(5'd9, 64'h2002, 8'd1, 3'd2, 3'b100, 32'h0000_0007, 10'd2, 4'h7, 1'b0);
    wait_drain("t3", 50);
    check_idle("t3_idle");

    // T4: 128 x 32 bytes = 4096 bytes -> length field 0; highest ID.
    base = w_pops;
    issue(5'd31, 64'h8000, 8'd127, 3'd5, 3'b101, 32'hFFFF_FFFF, 10'd0, 4'hF, 1'b0);
    wait_drain("t4", 400);
    check("t4_w_pops", w_pops - base, 128);
    check_idle("t4_idle");

    // T5: 8 beats (256 bytes = 64 DW) with header stall, random ready and W gaps.
    base = w_pops;
    hdr_ready = 1'b0;
    issue(5'd5, 64'h4000, 8'd7, 3'd5, 3'b011, 32'hFFFF_FFFF, 10'd64, 4'hF, 1'b0);
    n = 0;
    while ((exp_beat.size() != 0 || exp_hdr.size() != 0) && n < 300) begin
      @(posedge axi_clk); #2;
      hdr_ready  = (n >= 2);
      data_ready = ($urandom_range(0, 2) != 0);
      w_gap      = ($urandom_range(0, 3) == 0);
      n++;
    end
    data_ready = 1'b1;
    w_gap      = 1'b0;
    hdr_ready  = 1'b1;
    check("t5_drained", (exp_beat.size() == 0 && exp_hdr.size() == 0), 1);
    check("t5_w_pops", w_pops - base, 8);
    @(posedge axi_clk); #2;
    check_idle("t5_idle");

    // T6: back-to-back requests; second pop one cycle after the first's last beat.
    aw_rd_cyc.delete();
    last_hs_cyc.delete();
    issue(5'd1, 64'h3000, 8'd1, 3'd5, 3'b000, 32'hFFFF_FFFF, 10'd16, 4'hF, 1'b0);
    issue(5'd2, 64'h3100, 8'd0, 3'd5, 3'b000, 32'hFFFF_FFFF, 10'd8, 4'hF, 1'b0);
    wait_drain("t6", 50);
    check("t6_pop_count", aw_rd_cyc.size(), 2);
    check("t6_last_count", last_hs_cyc.size(), 2);
    if (aw_rd_cyc.size() == 2 && last_hs_cyc.size() >= 1)
      check("t6_bubble", aw_rd_cyc[1] - last_hs_cyc[0], 1);
    check_idle("t6_idle");

    // T7: reset after 2 of 4 beats, then a fresh request.
    base = hs_cnt;
    issue(5'd4, 64'h5000, 8'd3, 3'd5, 3'b001, 32'hFFFF_FFFF, 10'd32, 4'hF, 1'b0);
    n = 0;
    while (hs_cnt < base + 2 && n < 50) begin
      @(posedge axi_clk); #2;
      n++;
    end
    check("t7_two_beats", hs_cnt - base, 2);
    data_ready = 1'b0;
    ARESET     = 1'b1;
    aw_q.delete();
    w_q.delete();
    exp_beat.delete();
    @(posedge axi_clk); #2;
    ARESET     = 1'b0;
    data_ready = 1'b1;
    @(negedge axi_clk);
    check("t7_outputs_after_reset", {aw_fifo_rd_en, w_fifo_rd_en, rec_wr_en, rec_wr_addr, rec_wr_data,
                                     hdr_valid, hdr_addr, hdr_fmt_4dw, hdr_length, hdr_tag, hdr_first_be,
                                     hdr_last_be, hdr_user, data_valid, data, data_last}, 0);
    check("t7_no_extra_beat", hs_cnt - base, 2);
    @(posedge axi_clk); #2;

    // T8: 2 x 32 bytes = 64 bytes = 16 DW after reset.
    issue(5'd6, 64'h6000, 8'd1, 3'd5, 3'b110, 32'hFFFF_FFFF, 10'd16, 4'hF, 1'b0);
    wait_drain("t8", 50);
    check_idle("t8_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
